branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor
// ----------------------------------------------------------------------------
// Bimodal branch-direction predictor: a table of ENTRIES 2-bit saturating
// counters indexed by pc[log2(ENTRIES)+1:2]. Upper PC bits and the byte
// offset are ignored, so distinct branches may alias onto the same counter.
//
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// The prediction is the counter MSB.
//
// After reset the block sweeps the table (INIT), writing weak-NT (01) to one
// entry per cycle from index 0 upward. Once the last entry has been written
// it moves to RUN, raises ready and starts serving requests. RUN is left
// only through reset. The table itself carries no reset value; the sweep is
// what defines its contents.
//
// Optional feature (compile-time macro):
//   BRANCH_PREDICTOR_BYPASS_EN
//     defined   : a predict and an update that hit the same index in the same
//                 cycle return the MSB of the post-update counter.
//     undefined : the same case returns the MSB of the pre-update counter.
//   The update itself commits identically in both builds.
//
// Parameters:
//   ENTRIES        number of counters (power of two, at least 4)
//
// Ports:
//   clk            input   single clock, rising edge
//   reset          input   synchronous, active-high reset
//   ready          output  table initialisation complete
//   predict_valid  input   prediction request strobe (accepted every cycle)
//   predict_pc     input   32-bit address of the branch being fetched
//   predict_done   output  prediction result valid (one cycle after request)
//   predict_taken  output  predicted direction, 1 = taken (0 when not done)
//   update_valid   input   resolved-branch strobe
//   update_pc      input   32-bit address of the resolved branch
//   update_taken   input   actual branch outcome
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        predict_valid,
    input  logic [31:0] predict_pc,
    output logic        predict_done,
    output logic        predict_taken,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [1:0]       ctr_t;

    localparam ctr_t CTR_STRONG_NT = 2'b00;
    localparam ctr_t CTR_WEAK_NT   = 2'b01;
    localparam ctr_t CTR_STRONG_T  = 2'b11;
    localparam idx_t IDX_LAST      = idx_t'(ENTRIES - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Saturating counter step: move one position toward the observed outcome,
    // holding at the strong end states.
    // ------------------------------------------------------------------------
    function automatic ctr_t ctr_step(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_STRONG_T) begin
                nxt = cur + 2'b01;
            end
        end else begin
            if (cur != CTR_STRONG_NT) begin
                nxt = cur - 2'b01;
            end
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t state_q, state_d;
    idx_t   init_idx_q, init_idx_d;
    logic   ready_q, ready_d;
    logic   done_q, done_d;
    logic   taken_q, taken_d;

    // Counter storage; written by the INIT sweep or by RUN-mode updates.
    ctr_t   table_q [ENTRIES];

    // Single table write port, shared by the sweep and by updates (they are
    // never active in the same state).
    logic   wr_en;
    idx_t   wr_idx;
    ctr_t   wr_val;

    // ------------------------------------------------------------------------
    // Index extraction. The ignored PC bits are gathered into unused_pc_bits
    // so it is explicit that dropping them is intentional.
    // ------------------------------------------------------------------------
    idx_t pred_idx;
    idx_t upd_idx;
    logic unused_pc_bits;

    assign pred_idx = predict_pc[IDX_W+1:2];
    assign upd_idx  = update_pc[IDX_W+1:2];

    assign unused_pc_bits = ^{predict_pc[31:IDX_W+2], predict_pc[1:0],
                              update_pc[31:IDX_W+2],  update_pc[1:0]};

    // ------------------------------------------------------------------------
    // Counter read paths
    // ------------------------------------------------------------------------
    ctr_t upd_cur;
    ctr_t upd_next;
    ctr_t pred_ctr;
    logic same_idx;

    assign upd_cur  = table_q[upd_idx];
    assign upd_next = ctr_step(upd_cur, update_taken);
    assign same_idx = update_valid && (upd_idx == pred_idx);

`ifdef BRANCH_PREDICTOR_BYPASS_EN
    // Forward the counter being written this cycle to a colliding prediction.
    assign pred_ctr = same_idx ? upd_next : table_q[pred_idx];
`else
    // Colliding prediction sees the value held before this cycle's update.
    logic unused_same_idx;
    assign unused_same_idx = same_idx;
    assign pred_ctr        = table_q[pred_idx];
`endif

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        taken_d    = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = init_idx_q;
        wr_val     = CTR_WEAK_NT;

        unique case (state_q)
            S_INIT: begin
                // One weak-NT write per cycle; request strobes are ignored.
                wr_en      = 1'b1;
                wr_idx     = init_idx_q;
                wr_val     = CTR_WEAK_NT;
                init_idx_d = init_idx_q + idx_t'(1);
                if (init_idx_q == IDX_LAST) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end

            S_RUN: begin
                ready_d = 1'b1;
                done_d  = predict_valid;
                taken_d = predict_valid && pred_ctr[1];
                if (update_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = upd_idx;
                    wr_val = upd_next;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            taken_q    <= taken_d;
        end
    end

    // ------------------------------------------------------------------------
    // Counter table (no reset; contents defined by the INIT sweep)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_val;
        end
    end

    assign ready         = ready_q;
    assign predict_done  = done_q;
    assign predict_taken = taken_q;

endmodule
